// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin arbiter that shares one fixed-latency two-operand SPU op unit
// between N_REQ requesters. It picks at most one request per enabled cycle,
// drives the op unit inputs, and runs a {valid, id} tag pipe whose depth
// matches the op unit so every returning result is labelled with its owner.
module elixirchip_es1_spu_op_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_BITS  = 8,
  parameter int OP_LATENCY = 1,
  parameter int ID_BITS    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cke,
  input  logic [N_REQ-1:0]           s_valid,
  input  logic [N_REQ*DATA_BITS-1:0] s_data0,
  input  logic [N_REQ*DATA_BITS-1:0] s_data1,
  output logic [N_REQ-1:0]           s_ready,
  output logic [DATA_BITS-1:0]       op_data0,
  output logic [DATA_BITS-1:0]       op_data1,
  output logic                       op_valid,
  output logic                       op_clear,
  input  logic [DATA_BITS-1:0]       op_result,
  output logic                       m_valid,
  output logic [ID_BITS-1:0]         m_id,
  output logic [DATA_BITS-1:0]       m_data
);

  logic [DATA_BITS-1:0] data0_arr [N_REQ];
  logic [DATA_BITS-1:0] data1_arr [N_REQ];

  logic [N_REQ-1:0]   grant;
  logic [ID_BITS-1:0] grant_id;
  logic               grant_found;
  logic [ID_BITS-1:0] cand_idx;

  logic [ID_BITS-1:0] last_grant_q;
  logic [ID_BITS-1:0] last_grant_d;

  // Split the packed operand buses into one word per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data0_arr[gi] = s_data0[gi*DATA_BITS +: DATA_BITS];
    assign data1_arr[gi] = s_data1[gi*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search starting one past the last winner; cke gates every grant.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = ID_BITS'((int'(last_grant_q) + k) % N_REQ);
      if (cke && !grant_found && s_valid[cand_idx]) begin
        grant_found     = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_id        = cand_idx;
      end
    end
  end

  // Op unit drive; idle slots assert clear and present zero operands.
  always_comb begin
    s_ready  = grant;
    op_valid = grant_found;
    op_clear = ~grant_found;
    op_data0 = '0;
    op_data1 = '0;
    if (grant_found) begin
      op_data0 = data0_arr[grant_id];
      op_data1 = data1_arr[grant_id];
    end
  end

  // Pointer advances only when a grant is actually issued.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_found) begin
      last_grant_d = grant_id;
    end
  end

  // Pointer register; reset value makes requester 0 the first winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= ID_BITS'(N_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // The result path is a straight wire; alignment comes from the shared cke.
  assign m_data = op_result;

  if (OP_LATENCY == 0) begin : g_no_pipe
    assign m_valid = op_valid;
    assign m_id    = grant_id;
  end else begin : g_pipe
    logic [OP_LATENCY-1:0]              tag_valid_q;
    logic [OP_LATENCY-1:0]              tag_valid_d;
    logic [OP_LATENCY-1:0][ID_BITS-1:0] tag_id_q;
    logic [OP_LATENCY-1:0][ID_BITS-1:0] tag_id_d;

    // Tag shift: stage 0 takes the current grant, later stages follow; all hold on cke=0.
    always_comb begin
      tag_valid_d = tag_valid_q;
      tag_id_d    = tag_id_q;
      if (cke) begin
        tag_valid_d[0] = op_valid;
        tag_id_d[0]    = grant_id;
        for (int i = 1; i < OP_LATENCY; i++) begin
          tag_valid_d[i] = tag_valid_q[i-1];
          tag_id_d[i]    = tag_id_q[i-1];
        end
      end
    end

    // Tag registers; reset drops everything in flight.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_valid_q <= '0;
        tag_id_q    <= '0;
      end else begin
        tag_valid_q <= tag_valid_d;
        tag_id_q    <= tag_id_d;
      end
    end

    assign m_valid = tag_valid_q[OP_LATENCY-1];
    assign m_id    = tag_id_q[OP_LATENCY-1];
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Bench for the SPU op arbiter with N_REQ=4, OP_LATENCY=2 and a 2-deep xor
// op unit model. Stimulus pushes expected {id, data} into a queue when a
// grant is issued; a monitor pops and compares on each enabled m_valid.
module tb_elixirchip_es1_spu_op_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cke;
  logic [N-1:0]    s_valid;
  logic [N*DW-1:0] s_data0;
  logic [N*DW-1:0] s_data1;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   op_data0, op_data1, op_result, m_data;
  logic            op_valid, op_clear, m_valid;
  logic [1:0]      m_id;

  int compared   = 0;
  int mismatched = 0;
  logic [9:0] exp_q[$];

  elixirchip_es1_spu_op_arbiter #(
    .N_REQ(N), .DATA_BITS(DW), .OP_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1), .s_ready(s_ready),
    .op_data0(op_data0), .op_data1(op_data1), .op_valid(op_valid), .op_clear(op_clear),
    .op_result(op_result), .m_valid(m_valid), .m_id(m_id), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // xor op unit model, LATENCY=2, cke-stalled, clear yields 0.
  logic [DW-1:0] op_st0, op_st1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      op_st0 <= '0;
      op_st1 <= '0;
    end else if (cke) begin
      op_st0 <= op_clear ? 8'h00 : (op_data0 ^ op_data1);
      op_st1 <= op_st0;
    end
  end
  assign op_result = op_st1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] opnd0(input int i);
    return s_data0[i*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] opnd1(input int i);
    return s_data1[i*DW +: DW];
  endfunction

  // One clock cycle of stimulus; g is the hand-computed winner (-1 = none).
  task automatic cyc(input logic [N-1:0] v, input logic c, input int g);
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    s_valid = v;
    cke     = c;
    #1;
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    chk("op_valid", 32'(op_valid), 32'(g >= 0));
    chk("op_clear", 32'(op_clear), 32'(g < 0));
    if (g >= 0) begin
      exp_q.push_back({2'(g), opnd0(g) ^ opnd1(g)});
    end
    $display("cycle: s_valid=%b cke=%b s_ready=%b m_valid=%b m_id=%0d m_data=%h",
             v, c, s_ready, m_valid, m_id, m_data);
  endtask

  // Monitor: each enabled cycle with m_valid consumes one expected result.
  always @(negedge clk) begin
    if (!reset && cke && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(m_valid), 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("m_id", 32'(m_id), 32'(e[9:8]));
        chk("m_data", 32'(m_data), 32'(e[7:0]));
      end
    end
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_valid = '0;
    s_data0 = {8'h44, 8'h33, 8'h22, 8'h11};
    s_data1 = {8'h00, 8'hFF, 8'h0F, 8'hF0};
    #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_id", 32'(m_id), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // Idle: no requests -> clear asserted, nothing returns.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 1'b1, -1);
      chk("idle_m_valid", 32'(m_valid), 32'd0);
    end

    // All four requesting: strict 0,1,2,3 rotation; results arrive 2 cycles later.
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 1'b1, i % 4);
      chk("t1_m_valid_latency", 32'(m_valid), 32'(i >= 2));
    end

    // Requesters 0 and 3 alternate.
    cyc(4'b1001, 1'b1, 0);
    cyc(4'b1001, 1'b1, 3);
    cyc(4'b1001, 1'b1, 0);
    cyc(4'b1001, 1'b1, 3);
    repeat (3) cyc(4'b0000, 1'b1, -1);

    // Requester 2 alone, A5 ^ 0F = AA each cycle with no bubbles.
    s_data0[2*DW +: DW] = 8'hA5;
    s_data1[2*DW +: DW] = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b1, 2);
      chk("t2_expected", 32'(opnd0(2) ^ opnd1(2)), 32'h0000_00AA);
    end
    cyc(4'b0000, 1'b1, -1);
    chk("t2_m_data", 32'(m_data), 32'h0000_00AA);
    chk("t2_m_id", 32'(m_id), 32'd2);
    repeat (3) cyc(4'b0000, 1'b1, -1);

    // Stall: result of requester 1 sits at the output and must hold for 3 cycles.
    cyc(4'b0010, 1'b1, 1);
    cyc(4'b0001, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, -1);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_id", 32'(m_id), 32'd1);
      chk("stall_m_data", 32'(m_data), 32'h0000_002D);
    end
    cyc(4'b0000, 1'b1, -1);
    cyc(4'b0000, 1'b1, -1);
    chk("resume_m_id", 32'(m_id), 32'd0);
    chk("resume_m_data", 32'(m_data), 32'h0000_00E1);
    repeat (3) cyc(4'b0000, 1'b1, -1);

    // Asynchronous reset with two results in flight.
    cyc(4'b1111, 1'b1, 1);
    cyc(4'b1111, 1'b1, 2);
    @(posedge clk);
    #3;
    reset   = 1'b1;
    s_valid = '0;
    exp_q.delete();
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_m_id", 32'(m_id), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cyc(4'b1111, 1'b1, 0);
    cyc(4'b0000, 1'b1, -1);
    chk("post_rst_no_stale", 32'(m_valid), 32'd0);
    repeat (3) cyc(4'b0000, 1'b1, -1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/elixirchip_es1_spu_op_arbiter.md
Name: elixirchip_es1_spu_op_arbiter

Overview:
- Round-robin arbiter that shares one fixed-latency SPU two-operand op unit (xor/and/add-class, `LATENCY`-deep, `cke`-stalled, no backpressure) between `N_REQ` requesters.
- Grants at most one requester per cycle and drives the op unit's data0/data1/valid/clear inputs.
- Carries a `{valid, id}` tag pipeline matched to the op unit's latency, so each returning result is labelled with its requester.
- Sits between SPU issue logic and one shared op instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- DATA_BITS, 8, operand/result width.
- OP_LATENCY, 1, latency of the attached op unit; must equal that unit's LATENCY; legal >= 0.
- ID_BITS, $clog2(N_REQ), requester id width; derived, minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  **asynchronous, active-high reset**.
- cke  in  1  clock enable; also wired to the op unit's cke.
- s_valid  in  N_REQ  per-requester request.
- s_data0  in  N_REQ*DATA_BITS  operand 0; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- s_data1  in  N_REQ*DATA_BITS  operand 1; same packing.
- s_ready  out  N_REQ  one-hot grant; a request is accepted in a cycle where s_valid[i] & s_ready[i].
- op_data0  out  DATA_BITS  to op unit s_data0.
- op_data1  out  DATA_BITS  to op unit s_data1.
- op_valid  out  1  to op unit s_valid.
- op_clear  out  1  to op unit s_clear.
- op_result  in  DATA_BITS  from op unit m_data.
- m_valid  out  1  result valid.
- m_id  out  ID_BITS  requester id of the result.
- m_data  out  DATA_BITS  result; equals op_result.

Behaviour:
- Grant logic is combinational:
  - grant = round-robin pick among s_valid, qualified by cke.
  - Search starts at index (last_grant + 1) mod N_REQ.
  - s_ready = grant, so s_ready may depend on s_valid in the same cycle.
  - Requesters must not make s_valid depend on s_ready.
- last_grant register:
  - Reset value N_REQ-1, so index 0 has first priority.
  - Updates on the rising clk edge to the granted index only when cke=1 and some grant is issued; otherwise it holds.
- Op unit drive, all combinational:
  - op_valid = |grant.
  - op_data0/op_data1 = the granted requester's operands.
  - op_clear = ~op_valid, so idle slots produce the op unit's CLEAR_DATA.
  - With no grant, op_data0/op_data1 are driven to 0.
- Tag pipeline:
  - OP_LATENCY stages of {valid, id}.
  - Stage 0 loads {op_valid, granted id}; each stage shifts only when cke=1 and holds when cke=0.
  - m_valid/m_id come from the last stage.
  - OP_LATENCY=0: m_valid = op_valid and m_id = granted id, both combinational.
- m_data = op_result, pass-through with no register; it aligns with m_valid because the op unit and the tag pipe share cke.
- Throughput: one accepted operation per cycle while cke=1. No output backpressure; the consumer must always accept m_valid.
- Fairness: a requester holding s_valid continuously is granted within N_REQ cycles of cke=1.
- cke=0:
  - s_ready = 0 and op_valid = 0.
  - Tag pipe and last_grant freeze.
  - In-flight results resume when cke returns.
- Reset (asynchronous; mid-operation reset must behave the same):
  - All tag stages clear to valid=0, id=0, and last_grant = N_REQ-1.
  - Every in-flight result is dropped; m_valid=0 and m_id=0 while reset is asserted.
  - Combinational outputs follow inputs; the source must hold s_valid low during reset.
- Single requester: that requester is granted every cycle with no bubbles.
- Simultaneous requests: exactly one grant per cycle; s_ready is never multi-hot.

Test Plan:
- (N_REQ=4, OP_LATENCY=2, xor unit.) After reset, s_valid=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3. m_valid rises 2 cycles after the first grant with m_id sequence 0,1,2,3,0,1,2,3.
- Requester 2 alone with data0=8'hA5, data1=8'h0F for 3 cycles -> s_ready=4'b0100 each cycle. m_data=8'hAA with m_id=2 on cycles 2, 3, 4 after the first accept.
- s_valid=4'b1001 continuous -> grants alternate 0,3,0,3. No requester waits more than 1 cycle.
- Grant issued, then cke=0 for 3 cycles -> no new grants; m_valid/m_id/m_data hold. After cke=1, the result appears exactly OP_LATENCY enabled cycles after issue.
- Reset asserted asynchronously with 2 results in flight -> m_valid=0 immediately. After release, no stale result appears, and the first grant with s_valid=4'b1111 goes to requester 0.
- Idle cycles with no s_valid -> op_valid=0, op_clear=1, m_valid=0.
